// File: rtl/mdu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Iterative 32x32 multiply/divide unit with HI/LO result registers.
// Revision : 1.0 - initial release
// ============================================================================
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [2:0]  mduop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [5:0] LAST_STEP = 6'd31;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t      state;
  logic [31:0] opa, opb, orig_a, rem;
  logic [63:0] acc;
  logic [5:0]  cnt;
  logic        neg_q, neg_r, div0, is_div;

  logic        is_signed, sgn_a, sgn_b;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_shift;
  logic [31:0] div_sub;
  logic        div_fits;
  logic [63:0] prod;
  logic [31:0] quo, rmd;

  always_comb begin
    is_signed = (mduop == OP_MULT) || (mduop == OP_DIV);
    sgn_a     = is_signed & srca[31];
    sgn_b     = is_signed & srcb[31];
    abs_a     = sgn_a ? -srca : srca;
    abs_b     = sgn_b ? -srcb : srcb;
    // Multiply: acc = {partial product, remaining multiplier bits}
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
    // Divide: acc[31:0] shifts dividend bits out and quotient bits in
    div_shift = {rem, acc[31]};
    div_fits  = (div_shift >= {1'b0, opb});
    div_sub   = 32'(div_shift - {1'b0, opb});
    prod      = neg_q ? -acc : acc;
    quo       = neg_q ? -acc[31:0] : acc[31:0];
    rmd       = neg_r ? -rem : rem;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hi     <= 32'd0;
      lo     <= 32'd0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      orig_a <= 32'd0;
      rem    <= 32'd0;
      acc    <= 64'd0;
      cnt    <= 6'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      is_div <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mduop)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                opa    <= abs_a;
                opb    <= abs_b;
                orig_a <= srca;
                rem    <= 32'd0;
                cnt    <= 6'd0;
                neg_q  <= sgn_a ^ sgn_b;
                neg_r  <= sgn_a;
                div0   <= (srcb == 32'd0);
                is_div <= (mduop == OP_DIV) || (mduop == OP_DIVU);
                if ((mduop == OP_DIV) || (mduop == OP_DIVU)) begin
                  acc   <= {32'd0, abs_a};
                  state <= DIV;
                end else begin
                  acc   <= {32'd0, abs_b};
                  state <= MUL;
                end
              end
              OP_MTHI: hi <= srca;
              OP_MTLO: lo <= srca;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 6'd1;
          if (cnt == LAST_STEP) state <= FIX;
        end
        DIV: begin
          rem <= div_fits ? div_sub : div_shift[31:0];
          acc <= {acc[63:32], acc[30:0], div_fits};
          cnt <= cnt + 6'd1;
          if (cnt == LAST_STEP) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end else if (div0) begin
            hi <= orig_a;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= rmd;
            lo <= quo;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Purpose  : Directed self-checking bench for the mdu multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] srca, srcb;
  logic [2:0]  mduop;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .srca  (srca),
    .srcb  (srcb),
    .mduop (mduop),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Launch one iterative op; optionally fire a stray MULT start at cycle inj.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int inj);
    logic [31:0] old_hi, old_lo;
    int n;
    old_hi = hi;
    old_lo = lo;
    start = 1'b1; mduop = op; srca = a; srcb = b;
    tick();
    start = 1'b0; mduop = 3'b000;
    srca = $urandom; srcb = $urandom;
    n = 0;
    while (busy && n < 40) begin
      if (inj != 0 && n == inj) begin
        start = 1'b1; mduop = 3'b001; srca = 32'd3; srcb = 32'd5;
      end else begin
        start = 1'b0; mduop = 3'b000;
      end
      tick();
      n++;
      if (n == 16) check({tag, "_hold"}, {hi, lo}, {old_hi, old_lo});
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mduop = 3'b000; srca = 32'd0; srcb = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    run_op("mult_m2x3",   3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
    run_op("multu_max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_mixbig", 3'b001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 0);
    run_op("div_m7d2",    3'b011, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_7dm2",    3'b011, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0);
    run_op("divu_7d0",    3'b100, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 0);
    run_op("div_ovf",     3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0);
    run_op("div_m5d0",    3'b011, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

    // MTHI then MTLO on back-to-back edges
    start = 1'b1; mduop = 3'b101; srca = 32'h1234_5678;
    tick();
    check("mthi_hilo", {hi, lo}, {32'h1234_5678, 32'hFFFF_FFFF});
    check("mthi_busy", {63'd0, busy}, 64'd0);
    mduop = 3'b110; srca = 32'hCAFE_0000;
    tick();
    check("mtlo_hilo", {hi, lo}, {32'h1234_5678, 32'hCAFE_0000});
    check("mtlo_busy", {63'd0, busy}, 64'd0);

    // No-op encodings must be ignored
    mduop = 3'b000; srca = 32'h5555_5555; srcb = 32'd9;
    tick();
    check("nop0_busy", {63'd0, busy}, 64'd0);
    mduop = 3'b111;
    tick();
    check("nop7_busy", {63'd0, busy}, 64'd0);
    start = 1'b0; mduop = 3'b000;
    tick();
    check("nop_hilo", {hi, lo}, {32'h1234_5678, 32'hCAFE_0000});

    run_op("divu_ign", 3'b100, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    // Reset mid-multiply, with a competing MTHI start on the same edge
    start = 1'b1; mduop = 3'b010; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
    tick();
    start = 1'b0; mduop = 3'b000;
    repeat (9) tick();
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    reset = 1'b1; start = 1'b1; mduop = 3'b101; srca = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0; start = 1'b0; mduop = 3'b000;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    repeat (40) tick();
    check("abort_quiet", {31'd0, busy, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);

    run_op("multu_6x7", 3'b010, 32'd6, 32'd7, 32'd0, 32'd42, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 srca  input  32  operand A, same register-file read port that feeds the ALU; dividend or multiplicand.
REQ-004 srcb  input  32  operand B, same register-file read port that feeds the ALU; divisor or multiplier.
REQ-005 mduop  input  3  operation: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 000 and 111 are no-ops.
REQ-006 start  input  1  request qualifier; mduop/srca/srcb are sampled only on an edge where start=1.
REQ-007 busy  output  1  high while an iterative multiply/divide is in progress.
REQ-008 hi  output  32  HI register contents, registered.
REQ-009 lo  output  32  LO register contents, registered.

Function
REQ-010 The FSM SHALL have states IDLE, MUL, DIV, FIX; busy SHALL be 1 exactly when the state is not IDLE (decoded from the state register, no input path).
REQ-011 In IDLE with start=1 and mduop MULT/MULTU, the MDU SHALL capture |srca|, |srcb| (signed ops) or raw values (unsigned), capture result sign flags, clear the 6-bit iteration counter, and enter MUL.
REQ-012 In IDLE with start=1 and mduop DIV/DIVU, the MDU SHALL capture operands in the same way, also hold original srca, and enter DIV.
REQ-013 MUL SHALL perform one shift-add step per cycle over a 64-bit accumulator; after 32 steps (counter=31) the FSM SHALL enter FIX.
REQ-014 DIV SHALL perform one restoring-division step per cycle (33-bit partial remainder); after 32 steps the FSM SHALL enter FIX.
REQ-015 FIX SHALL apply signs, write hi/lo, and return to IDLE in one cycle.
REQ-016 Latency: if start is accepted on edge E0, busy SHALL be 1 after E0 through E32, then 0 after E33, with hi/lo holding the new result after E33 (33 busy cycles).
REQ-017 MULT/MULTU: {hi,lo} SHALL equal the full 64-bit product, two's-complement signed for MULT, unsigned for MULTU.
REQ-018 DIV: lo SHALL be the quotient truncated toward zero; hi SHALL be the remainder with the sign of the dividend; DIVU produces unsigned quotient/remainder.
REQ-019 Division by zero (srcb=0, DIV or DIVU) SHALL yield lo=32'hFFFF_FFFF, hi=original srca, with the normal 33-cycle timing.
REQ-020 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL yield lo=32'h8000_0000, hi=0.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write srca to hi/lo at that edge, leave the other register unchanged, and never assert busy.
REQ-022 Any start while busy=1 SHALL be ignored entirely, with no effect on the operation in progress or on hi/lo.
REQ-023 start with mduop 000 or 111 SHALL be ignored.
REQ-024 hi/lo SHALL change only at the FIX edge, an accepted MTHI/MTLO edge, or reset; in-progress intermediate values SHALL never appear on hi/lo.
REQ-025 Operand inputs SHALL not be used after the accepting edge; changes to srca/srcb during busy SHALL not affect the result.

Reset
REQ-026 On reset=1 at a rising edge: state=IDLE, busy=0, hi=0, lo=0, counter=0, and all working registers cleared.
REQ-027 Reset SHALL take priority over start in the same cycle and SHALL abort any in-progress operation with no partial hi/lo update.

Verification
REQ-028 MULT srca=32'hFFFF_FFFE (-2), srcb=3 -> after 33 busy cycles, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
REQ-029 MULTU srca=srcb=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-030 DIV srca=-7 (32'hFFFF_FFF9), srcb=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU 7/0 -> lo=32'hFFFF_FFFF, hi=7.
REQ-031 MTHI 32'h1234_5678 then MTLO 32'hCAFE_0000 on consecutive edges -> hi/lo update each at its own edge, busy stays 0.
REQ-032 Start DIVU 100/7, then issue MULT start on cycle 5 while busy -> MULT ignored, result lo=14, hi=2.
REQ-033 Start MULTU, assert reset at cycle 10 -> busy=0, hi=lo=0 after that edge; a new MULTU 6*7 then gives lo=42, hi=0.
